// File: rtl/parity_combination_walker_pkg.sv
// Shared definitions for the parity combination walker: count widths and walker state encoding.
package parity_combination_walker_pkg;

    localparam int unsigned DEFAULT_MAX_BUTTON_COUNT = 13;
    localparam int unsigned CW = $clog2(DEFAULT_MAX_BUTTON_COUNT + 1);

    typedef enum logic [2:0] {
        IDLE,
        BUILD,
        WAIT_TABLE,
        REQ_FIRST,
        WAIT_FIRST,
        REQ_NEXT,
        WAIT_NEXT,
        DONE
    } walker_state_t;

    function automatic int unsigned count_width(input int unsigned max_buttons);
        return $clog2(max_buttons + 1);
    endfunction

endpackage

// File: rtl/parity_combination_walker_popcount.sv
// Number of pressed buttons in one combination.
module combination_popcount
    import parity_combination_walker_pkg::*;
#(
    parameter int unsigned MAX_BUTTON_COUNT = DEFAULT_MAX_BUTTON_COUNT
) (
    input  logic [MAX_BUTTON_COUNT:0]                   combination,
    output logic [count_width(MAX_BUTTON_COUNT)-1:0]    press_count
);

    localparam int unsigned CNT_W = count_width(MAX_BUTTON_COUNT);

    always_comb begin
        press_count = '0;
        for (int unsigned i = 0; i <= MAX_BUTTON_COUNT; i++) begin
            press_count = press_count + CNT_W'(combination[i]);
        end
    end

endmodule

// File: rtl/parity_combination_walker.sv
// Requesting side of the parity-to-combination table: optional build, then walks one
// parity list and keeps the combination with the fewest pressed buttons.
module parity_combination_walker
    import parity_combination_walker_pkg::*;
#(
    parameter int unsigned MACHINE_COUNT    = 10,
    parameter int unsigned MAX_BUTTON_COUNT = DEFAULT_MAX_BUTTON_COUNT,
    parameter int unsigned RESPONSE_TIMEOUT = 15
) (
    input  logic                                        clk,
    input  logic                                        reset_n,
    input  logic                                        start,
    input  logic                                        rebuild,
    input  logic [count_width(MAX_BUTTON_COUNT)-1:0]    button_count,
    input  logic [MACHINE_COUNT-1:0]                    target_parity,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        found,
    output logic                                        error,
    output logic [MAX_BUTTON_COUNT:0]                   best_combination,
    output logic [count_width(MAX_BUTTON_COUNT)-1:0]    best_press_count,
    output logic [MAX_BUTTON_COUNT:0]                   candidates_seen,
    output logic                                        build_parity_table,
    output logic                                        find_first_combination_for_parity,
    output logic                                        find_next_combination_for_combination,
    output logic [MAX_BUTTON_COUNT:0]                   combination_upper_bound,
    output logic [MACHINE_COUNT-1:0]                    parity_to_search,
    output logic [MAX_BUTTON_COUNT:0]                   previous_combination,
    input  logic                                        parity_table_complete,
    input  logic                                        request_ready,
    input  logic                                        parity_list_created,
    input  logic                                        next_combination_valid,
    input  logic [MAX_BUTTON_COUNT:0]                   first_combination_for_parity,
    input  logic [MAX_BUTTON_COUNT:0]                   next_combination_for_combination
);

    localparam int unsigned CNT_W       = count_width(MAX_BUTTON_COUNT);
    localparam int unsigned CMB_W       = MAX_BUTTON_COUNT + 1;
    localparam int unsigned BUILD_BOUND = (1 << MAX_BUTTON_COUNT) * 2 + 4;
    localparam int unsigned TMR_W       = $clog2(BUILD_BOUND + RESPONSE_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] MAX_COUNT = CNT_W'(MAX_BUTTON_COUNT);

    walker_state_t      state, state_next;
    logic [TMR_W-1:0]   timer;
    logic [TMR_W-1:0]   wait_limit;
    logic               built;
    logic               evaluate;
    logic               timed_out;
    logic [CMB_W-1:0]   eval_combination;
    logic [CNT_W-1:0]   eval_press_count;

    assign busy                                  = (state != IDLE) && (state != DONE);
    assign done                                  = (state == DONE);
    assign build_parity_table                    = (state == BUILD);
    assign find_first_combination_for_parity     = (state == REQ_FIRST);
    assign find_next_combination_for_combination = (state == REQ_NEXT);

    assign eval_combination = (state == WAIT_FIRST) ? first_combination_for_parity
                                                    : next_combination_for_combination;

    combination_popcount #(
        .MAX_BUTTON_COUNT (MAX_BUTTON_COUNT)
    ) u_popcount (
        .combination (eval_combination),
        .press_count (eval_press_count)
    );

    always_comb begin
        state_next = state;
        evaluate   = 1'b0;
        timed_out  = 1'b0;
        wait_limit = TMR_W'(RESPONSE_TIMEOUT);
        case (state)
            IDLE: begin
                if (start) begin
                    if (button_count > MAX_COUNT) state_next = DONE;
                    else if (rebuild)             state_next = BUILD;
                    else                          state_next = WAIT_TABLE;
                end
            end
            BUILD:      state_next = WAIT_TABLE;
            WAIT_TABLE: begin
                if (built) wait_limit = TMR_W'(BUILD_BOUND);
                // complete may still reflect the previous table on the first cycle after a build
                if (parity_table_complete && !(built && timer == '0)) begin
                    state_next = REQ_FIRST;
                end else if (timer == wait_limit - 1'b1) begin
                    state_next = DONE;
                    timed_out  = 1'b1;
                end
            end
            REQ_FIRST:  state_next = WAIT_FIRST;
            WAIT_FIRST: begin
                if (request_ready) begin
                    if (parity_list_created) begin
                        evaluate   = 1'b1;
                        state_next = REQ_NEXT;
                    end else begin
                        state_next = DONE;
                    end
                end else if (timer == wait_limit - 1'b1) begin
                    state_next = DONE;
                    timed_out  = 1'b1;
                end
            end
            REQ_NEXT:   state_next = WAIT_NEXT;
            WAIT_NEXT: begin
                if (request_ready) begin
                    if (next_combination_valid) begin
                        evaluate   = 1'b1;
                        state_next = REQ_NEXT;
                    end else begin
                        state_next = DONE;
                    end
                end else if (timer == wait_limit - 1'b1) begin
                    state_next = DONE;
                    timed_out  = 1'b1;
                end
            end
            DONE:       state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_next;
            if (state_next != state)
                timer <= '0;
            else if (state inside {WAIT_TABLE, WAIT_FIRST, WAIT_NEXT})
                timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            built                   <= 1'b0;
            found                   <= 1'b0;
            error                   <= 1'b0;
            best_combination        <= '0;
            best_press_count        <= '0;
            candidates_seen         <= '0;
            combination_upper_bound <= '0;
            parity_to_search        <= '0;
            previous_combination    <= '0;
        end else if (state == IDLE && start) begin
            built                   <= rebuild;
            found                   <= 1'b0;
            error                   <= (button_count > MAX_COUNT);
            best_combination        <= '0;
            best_press_count        <= '0;
            candidates_seen         <= '0;
            combination_upper_bound <= CMB_W'(1) << button_count;
            parity_to_search        <= target_parity;
        end else begin
            if (timed_out) error <= 1'b1;
            if (evaluate) begin
                if (candidates_seen != '1) candidates_seen <= candidates_seen + 1'b1;
                // strict compare keeps the earliest (lowest-valued) entry on ties
                if (!found || eval_press_count < best_press_count) begin
                    best_combination <= eval_combination;
                    best_press_count <= eval_press_count;
                end
                found                <= 1'b1;
                previous_combination <= eval_combination;
            end
        end
    end

endmodule
